// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the six seven-segment digits; each grant lasts DWELL cycles
// unless held by `hold` or released early when the owner drops its request.
module hex_display_arbiter #(
    parameter int N_REQ = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic                 max10_clk1_50,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [24*N_REQ-1:0]  value,
    input  logic                 hold,
    output logic [N_REQ-1:0]     grant,
    output logic [7:0]           hex0,
    output logic [7:0]           hex1,
    output logic [7:0]           hex2,
    output logic [7:0]           hex3,
    output logic [7:0]           hex4,
    output logic [7:0]           hex5
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SHOW = 1'b1;

    function automatic logic [7:0] seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // r_rr doubles as the current owner while in SHOW: it is always loaded with the winner
    logic [0:0]          r_state;
    logic [IW-1:0]       r_rr;
    logic [CW-1:0]       r_cnt;
    logic [N_REQ-1:0]    r_grant;
    logic [5:0][7:0]     r_hex;

    logic                w_found;
    logic [IW-1:0]       w_win;
    logic [0:0]          w_next_state;
    logic [IW-1:0]       w_next_rr;
    logic [CW-1:0]       w_next_cnt;
    logic                w_next_show;
    logic [23:0]         w_val_arr [N_REQ];
    logic [23:0]         w_sel_val;
    logic [5:0][7:0]     w_next_hex;

    // Descending scan so the smallest offset from r_rr+1 is written last and wins
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            j = (int'(r_rr) + i) % N_REQ;
            if (req[j[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = j[IW-1:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_rr    = r_rr;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = S_SHOW;
                    w_next_rr    = w_win;
                    w_next_cnt   = RELOAD;
                end
            end
            default: begin
                if (!req[r_rr] || (r_cnt == '0 && !hold)) begin
                    if (w_found) begin
                        w_next_rr  = w_win;
                        w_next_cnt = RELOAD;
                    end else begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = '0;
                    end
                end else if (r_cnt == '0) begin
                    w_next_cnt = RELOAD;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
        endcase
        w_next_show = (w_next_state == S_SHOW);
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_val_arr[i] = value[24*i +: 24];
        end
        w_sel_val = w_val_arr[w_next_rr];
        for (int k = 0; k < 6; k++) begin
            w_next_hex[k] = w_next_show ? seg(w_sel_val[4*k +: 4]) : 8'hFF;
        end
        w_next_hex[0][7] = ~(w_next_show & hold);
    end

    always_ff @(posedge max10_clk1_50) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rr    <= IW'(N_REQ - 1);
            r_cnt   <= '0;
            r_grant <= '0;
            r_hex   <= {6{8'hFF}};
        end else begin
            r_state <= w_next_state;
            r_rr    <= w_next_rr;
            r_cnt   <= w_next_cnt;
            r_grant <= w_next_show ? (N_REQ'(1) << w_next_rr) : '0;
            r_hex   <= w_next_hex;
        end
    end

    assign grant = r_grant;
    assign hex0  = r_hex[0];
    assign hex1  = r_hex[1];
    assign hex2  = r_hex[2];
    assign hex3  = r_hex[3];
    assign hex4  = r_hex[4];
    assign hex5  = r_hex[5];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with DWELL=4, N_REQ=4.
module tb_hex_display_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [95:0] value;
    logic        hold;
    logic [3:0]  grant;
    logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int n_cmp;
    int n_err;

    hex_display_arbiter #(.N_REQ(4), .DWELL(4)) dut (
        .max10_clk1_50 (clk),
        .reset         (reset),
        .req           (req),
        .value         (value),
        .hold          (hold),
        .grant         (grant),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3),
        .hex4          (hex4),
        .hex5          (hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_hex"}, {16'h0, hex5, hex4}, 32'hFFFF);
        chk({tag, "_hexlo"}, {hex3, hex2, hex1, hex0}, 32'hFFFF_FFFF);
    endtask

    logic [3:0] exp_g   [5];
    logic [7:0] exp_h0  [5];

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        req   = 4'b0000;
        hold  = 1'b0;
        value = '0;
        exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_h0 = '{8'h92, 8'hF9, 8'hA4, 8'hB0, 8'h92};

        // 1: reset, then idle with no requests
        tick(); tick();
        chk_blank("reset");
        reset = 1'b0;
        tick();
        chk_blank("idle_noreq");

        // 2: single requester, digit decode
        value[23:0] = 24'h012345;
        req = 4'b0001;
        tick();
        chk("s2_grant", 32'(grant), 32'h1);
        chk("s2_hex0", 32'(hex0), 32'h92);
        chk("s2_hex1", 32'(hex1), 32'h99);
        chk("s2_hex2", 32'(hex2), 32'hB0);
        chk("s2_hex3", 32'(hex3), 32'hA4);
        chk("s2_hex4", 32'(hex4), 32'hF9);
        chk("s2_hex5", 32'(hex5), 32'hC0);
        tick();
        reset = 1'b1;
        tick();
        chk_blank("reset_mid_show");
        reset = 1'b0;

        // 3: full rotation, 4 cycles per owner
        value = {24'h333333, 24'h222222, 24'h111111, 24'h012345};
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk($sformatf("rot%0d_%0d_grant", s, c), 32'(grant), 32'(exp_g[s]));
                chk($sformatf("rot%0d_%0d_hex0", s, c), 32'(hex0), 32'(exp_h0[s]));
            end
        end

        // 4: hold freezes grant 0001 and lights hex0 dp
        req  = 4'b0101;
        hold = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk($sformatf("hold%0d_grant", c), 32'(grant), 32'h1);
            chk($sformatf("hold%0d_hex0", c), 32'(hex0), 32'h12);
        end
        hold = 1'b0;
        tick();
        chk("unhold_grant", 32'(grant), 32'h4);
        chk("unhold_hex0", 32'(hex0), 32'hA4);

        // 5: early release
        req = 4'b0001;
        tick();
        chk("rel2_grant", 32'(grant), 32'h1);
        chk("rel2_hex0", 32'(hex0), 32'h92);
        tick();
        chk("rel2b_grant", 32'(grant), 32'h1);
        req = 4'b0100;
        tick();
        chk("rel0_grant", 32'(grant), 32'h4);
        req = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("reload%0d_grant", c), 32'(grant), 32'h4);
        end
        tick();
        chk("reload_exp_grant", 32'(grant), 32'h1);

        // 6: sole owner keeps grant across expiry; live value update; all drop -> idle
        req = 4'b0001;
        tick();
        chk("solo0_grant", 32'(grant), 32'h1);
        value[23:0] = 24'hABCDEF;
        tick();
        chk("live_hex0", 32'(hex0), 32'h8E);
        chk("live_hex5", 32'(hex5), 32'h88);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("solo%0d_grant", c + 2), 32'(grant), 32'h1);
        end
        req = 4'b0000;
        tick();
        chk_blank("all_drop");
        tick();
        chk_blank("idle_stay");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
